// File: rtl/instr_window.sv
// instr_window: fetch-to-issue instruction FIFO with show-ahead head and flush
module instr_window #(
  parameter int DEPTH = 8,
  parameter int PKT_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_iw_valid_i,
  output logic             iw_fetch_ready_o,
  input  logic [PKT_W-1:0] fetch_iw_instr_packet_i,
  input  logic             flush_i,
  output logic             iw_issue_valid_o,
  input  logic             issue_iw_ready_i,
  output logic [PKT_W-1:0] iw_issue_instr_packet_o,
  output logic [CNT_W-1:0] iw_count_o
);
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  // ready is held low during reset; a full window never accepts, even alongside a pop
  assign iw_fetch_ready_o        = rst_ni && (count_q < CNT_W'(DEPTH)) && !flush_i;
  assign iw_issue_valid_o        = (count_q != '0) && !flush_i;
  assign iw_issue_instr_packet_o = mem_q[rd_ptr_q];
  assign iw_count_o              = count_q;
  assign push = fetch_iw_valid_i && iw_fetch_ready_o;
  assign pop  = iw_issue_valid_o && issue_iw_ready_i;
  always_comb begin
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d  = flush_i ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= fetch_iw_instr_packet_i;
  end
endmodule

// File: tb/tb_instr_window.sv
// tb_instr_window: vector table plus queue scoreboard for the instruction window
module tb_instr_window;
  localparam int DEPTH = 8;
  typedef struct {
    logic        v, r, f;
    logic [31:0] p;
    logic        er, ev;
    logic [3:0]  ec;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fetch_v = 1'b0, flush = 1'b0, issue_r = 1'b0;
  logic [31:0] fetch_pkt = '0;
  logic        fready, ivalid;
  logic [31:0] ipkt;
  logic [3:0]  icount;
  int          checks = 0, errors = 0;
  logic [31:0] sb [$];
  vec_t        tbl [$];
  logic        hold_q = 1'b0;
  logic [31:0] hold_pkt = '0;
  instr_window #(.DEPTH(DEPTH), .PKT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_iw_valid_i(fetch_v), .iw_fetch_ready_o(fready),
    .fetch_iw_instr_packet_i(fetch_pkt), .flush_i(flush),
    .iw_issue_valid_o(ivalid), .issue_iw_ready_i(issue_r),
    .iw_issue_instr_packet_o(ipkt), .iw_count_o(icount)
  );
  always #5 clk = ~clk;
  // Fetch must hold a refused packet stable until it is accepted
  always @(posedge clk) begin
    if (hold_q) assert (fetch_v && fetch_pkt == hold_pkt) else $error("protocol: fetch packet dropped or changed while waiting");
    hold_q   <= rst_n && fetch_v && !fready;
    hold_pkt <= fetch_pkt;
  end
  function automatic vec_t mk(logic v, r, f, logic [31:0] p, logic er, ev, logic [3:0] ec);
    mk = '{v: v, r: r, f: f, p: p, er: er, ev: ev, ec: ec};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic v, r, f, input logic [31:0] p);
    fetch_v = v; issue_r = r; flush = f; fetch_pkt = p;
    #1;
  endtask
  task automatic tick();
    logic er, ev;
    er = (sb.size() < DEPTH) && !flush;
    ev = (sb.size() != 0) && !flush;
    chk("ready", 32'(fready), 32'(er));
    chk("valid", 32'(ivalid), 32'(ev));
    chk("count", 32'(icount), 32'(sb.size()));
    if (ev && issue_r) chk("data", ipkt, sb.pop_front());
    if (er && fetch_v) sb.push_back(fetch_pkt);
    if (flush) sb.delete();
    @(posedge clk); #1;
  endtask
  task automatic pushes(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin drive(1, 0, 0, base + 32'(i)); tick(); end
  endtask
  task automatic pops(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 1, 0, 0); tick(); end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 32'(i + 1), 1, i != 0, 4'(i)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8));
    for (int j = 0; j < 8; j++) tbl.push_back(mk(0, 1, 0, 0, j != 0, 1, 4'(8 - j)));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0));
    #3;
    chk("rst_ready", 32'(fready), 0);
    chk("rst_valid", 32'(ivalid), 0);
    chk("rst_count", 32'(icount), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    // fill then drain, empty pops ignored at the end
    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].r, tbl[k].f, tbl[k].p);
      chk($sformatf("tbl%0d_ready", k), 32'(fready), 32'(tbl[k].er));
      chk($sformatf("tbl%0d_valid", k), 32'(ivalid), 32'(tbl[k].ev));
      chk($sformatf("tbl%0d_count", k), 32'(icount), 32'(tbl[k].ec));
      tick();
    end
    // streaming at one packet per cycle
    for (int k = 0; k < 20; k++) begin drive(1, 1, 0, 32'h100 + 32'(k)); tick(); end
    chk("stream_count", 32'(icount), 1);
    pops(1);
    // full with simultaneous pop: first cycle pops only
    pushes(8, 32'h200);
    drive(1, 1, 0, 32'h300); tick();
    chk("full_pop_count", 32'(icount), 7);
    drive(1, 1, 0, 32'h300); tick();
    chk("full_both_count", 32'(icount), 7);
    pops(7);
    // wrap-around
    pushes(5, 32'h400); pops(5);
    pushes(6, 32'h410); pops(6);
    // flush with traffic, then the next packet is the first issued
    pushes(5, 32'h500);
    drive(1, 1, 1, 32'h600); tick();
    drive(1, 0, 0, 32'h600); tick();
    pops(1);
    chk("flush_drained", 32'(icount), 0);
    // back-to-back flushes
    pushes(2, 32'h700);
    drive(0, 1, 1, 0); tick();
    drive(0, 1, 1, 0); tick();
    pops(1);
    // async reset between edges
    pushes(3, 32'h800);
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ivalid), 0);
    chk("arst_count", 32'(icount), 0);
    chk("arst_ready", 32'(fready), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pushes(2, 32'h900);
    pops(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_window.md
Name: instr_window

Overview:
- Consumer end of the fetch-to-instruction-window handshake: the instruction window, written by the Fetch stage.
- Accepts fetch instruction packets with a valid/ready handshake and buffers them in a circular FIFO.
- Presents the oldest packet to the downstream issue stage with a second valid/ready handshake.
- Supports a pipeline flush that discards all buffered packets.

Parameters:
- DEPTH, 8, number of buffered packets; power of two, minimum 2.
- PKT_W, $bits(core_instr_packet_t), width of one instruction packet.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clock  input  1  core clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_iw_valid  input  1  Fetch holds a valid packet.
- iw_fetch_ready  output  1  window can accept a packet this cycle.
- fetch_iw_instr_packet  input  PKT_W  packet from Fetch (core_instr_packet_t).
- flush  input  1  synchronous discard of all entries.
- iw_issue_valid  output  1  head packet available to issue.
- issue_iw_ready  input  1  issue stage takes head packet.
- iw_issue_instr_packet  output  PKT_W  head packet (show-ahead).
- iw_count  output  CNT_W  current occupancy.

Behaviour:
- Reset (reset==0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - iw_issue_valid=0, iw_fetch_ready=0 while reset is asserted; iw_count=0.
  - Storage contents are don't-care.
- Reset deassert: iw_fetch_ready=1 in the first cycle out of reset.
- Readiness and validity (combinational from registered state):
  - iw_fetch_ready = (count < DEPTH) && !flush.
  - iw_issue_valid = (count != 0) && !flush.
  - iw_issue_instr_packet = mem[rd_ptr]. Must be 0 or stable garbage when empty; only meaningful when iw_issue_valid.
- Push: fetch_iw_valid && iw_fetch_ready at the rising edge writes mem[wr_ptr], then wr_ptr++.
- Pop: iw_issue_valid && issue_iw_ready at the rising edge advances rd_ptr++.
- Count update: count += push - pop. Push and pop in the same cycle leave count unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Latency:
  - Accepted packet is visible at iw_issue_valid the cycle after acceptance. No empty bypass, so minimum latency is 1 cycle.
  - Throughput is 1 packet/cycle in steady state.
- Full: iw_fetch_ready=0 even if a pop occurs the same cycle; no full-bypass. A pop frees one slot, and ready rises the next cycle.
- Empty: iw_issue_valid=0; issue_iw_ready is ignored and no pointer moves.
- Flush:
  - In the flush cycle, ready and valid are both forced low, so no push and no pop occur.
  - Next cycle: wr_ptr=rd_ptr=count=0.
  - Flush overrides any simultaneous handshake.
  - Back-to-back flush cycles keep the window empty.
- Protocol obligation on Fetch: once fetch_iw_valid=1, the packet is held stable until accepted. The bench asserts this. The window does not depend on it for correctness beyond capturing the value at the accept edge.
- Ordering: strict FIFO order; no reordering, no duplication, no loss except on flush or reset.
- Reset mid-operation clears all state immediately, independent of clock. Buffered packets are discarded.

Test Plan:
- Fill then drain, DEPTH=8:
  - Stimulus: push packets 0x01..0x08 with issue_iw_ready=0.
  - Required: iw_fetch_ready drops after the 8th accept and iw_count=8.
  - Then raise issue_iw_ready: packets emerge 0x01..0x08 in order on consecutive cycles and iw_count returns to 0.
- Streaming:
  - Stimulus: fetch_iw_valid and issue_iw_ready held high for 20 cycles, sequential packets.
  - Required: 1 packet/cycle after 1-cycle fill latency, iw_count constant at 1, no gaps or duplicates.
- Full with simultaneous pop:
  - Stimulus: count=8, fetch valid and issue ready both high.
  - Required: cycle 0 pop only (count=7); cycle 1 push and pop (count stays 7); no accept happens while ready is low.
- Wrap-around:
  - Stimulus: push 5, pop 5, push 6, pop 6.
  - Required: pointers wrap past 7 and data order is preserved.
- Flush with traffic:
  - Stimulus: count=5, flush=1 with fetch valid and issue ready high.
  - Required: neither handshake completes that cycle; next cycle iw_count=0, iw_issue_valid=0, iw_fetch_ready=1.
  - Next pushed packet is the first issued.
- Async reset mid-stream:
  - Stimulus: assert reset low between clock edges with count=3.
  - Required: iw_issue_valid=0 and iw_count=0 immediately, before the next edge.
  - After release, window is empty and accepts new packets.
